// File: rtl/i2c_pkg.sv
// Shared types and bus-level constants for the I2C register target.
package i2c_pkg;
   localparam int I2C_ADDR_W = 7;
   localparam logic ACK_LVL  = 1'b0;
   localparam logic NACK_LVL = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      WR_DATA,
      RD_DATA,
      RD_ACK
   } state_t;
endpackage

// File: rtl/i2c_target_regs_if.sv
// Pin-side and register-write-side signals of the I2C register target.
interface i2c_target_regs_if;
   logic       scl_i;
   logic       sda_i;
   logic       sda_oe;
   logic       wr_valid;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;

   modport slave (
      input  scl_i, sda_i,
      output sda_oe, wr_valid, wr_addr, wr_data, busy
   );

   modport master (
      output scl_i, sda_i,
      input  sda_oe, wr_valid, wr_addr, wr_data, busy
   );
endinterface

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser plus FILTER_LEN-sample glitch filter for one I2C line,
// with single-cycle rise/fall flags on the filtered level.
module i2c_line_filter #(
   parameter int FILTER_LEN = 3
) (
   input  logic clk48,
   input  logic reset_n,
   input  logic line_in,
   output logic level,
   output logic rise,
   output logic fall
);
   localparam int CW = $clog2(FILTER_LEN + 1);

   logic          sync1;
   logic          sync2;
   logic          level_d;
   logic [CW-1:0] cnt;

   // An idle bus floats high, so every stage resets to 1.
   always_ff @(posedge clk48 or negedge reset_n) begin
      if (!reset_n) begin
         sync1   <= 1'b1;
         sync2   <= 1'b1;
         level   <= 1'b1;
         level_d <= 1'b1;
         cnt     <= '0;
      end else begin
         sync1   <= line_in;
         sync2   <= sync1;
         level_d <= level;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CW'(FILTER_LEN - 1)) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign rise = level & ~level_d;
   assign fall = ~level & level_d;
endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a byte register file and auto-incrementing pointer;
// SDA is only ever pulled low (open drain), never driven high.
module i2c_target_regs
   import i2c_pkg::*;
#(
   parameter logic [I2C_ADDR_W-1:0] I2C_ADDR   = 7'h50,
   parameter int                    NUM_REGS   = 16,
   parameter int                    FILTER_LEN = 3
) (
   input logic              clk48,
   input logic              reset_n,
   i2c_target_regs_if.slave bus
);
   localparam int         PW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [7:0] PTR_MASK = 8'(NUM_REGS - 1);

   logic scl_f, scl_rise, scl_fall;
   logic sda_f, sda_rise, sda_fall;
   logic start, stop;

   state_t     state_q, state_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shreg_q, shreg_d;
   logic [7:0] ptr_q, ptr_d;
   logic [7:0] wr_addr_q, wr_addr_d;
   logic [7:0] wr_data_q, wr_data_d;
   logic       rw_q, rw_d;
   logic       sda_oe_q, sda_oe_d;
   logic       wr_valid_q, wr_valid_d;
   logic [7:0] byte_in;
   logic [7:0] rd_byte;
   logic [7:0] regs [NUM_REGS];

   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
      .clk48(clk48), .reset_n(reset_n), .line_in(bus.scl_i),
      .level(scl_f), .rise(scl_rise), .fall(scl_fall)
   );

   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
      .clk48(clk48), .reset_n(reset_n), .line_in(bus.sda_i),
      .level(sda_f), .rise(sda_rise), .fall(sda_fall)
   );

   assign start   = sda_fall & scl_f;
   assign stop    = sda_rise & scl_f;
   assign byte_in = {shreg_q[6:0], sda_f};
   assign rd_byte = regs[ptr_q[PW-1:0]];

   // bit_cnt 8 = byte received, ACK pending; 9 = ACK on the bus for the 9th clock.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
      ptr_d      = ptr_q;
      rw_d       = rw_q;
      sda_oe_d   = sda_oe_q;
      wr_valid_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      if (stop) begin
         state_d  = IDLE;
         sda_oe_d = 1'b0;
      end else if (start) begin
         state_d   = ADDR;
         bit_cnt_d = '0;
         sda_oe_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: ;
            ADDR, ADDR_ACK, PTR, WR_DATA: begin
               if (scl_rise && bit_cnt_q < 4'd8) begin
                  shreg_d   = byte_in;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     if (state_q == ADDR) begin
                        if (byte_in[7:1] == I2C_ADDR) begin
                           state_d = ADDR_ACK;
                           rw_d    = byte_in[0];
                        end else begin
                           state_d = IDLE;
                        end
                     end else if (state_q == PTR) begin
                        ptr_d = byte_in & PTR_MASK;
                     end else if (state_q == WR_DATA) begin
                        wr_valid_d = 1'b1;
                        wr_addr_d  = ptr_q;
                        wr_data_d  = byte_in;
                        ptr_d      = (ptr_q + 8'd1) & PTR_MASK;
                     end
                  end
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  sda_oe_d  = ~ACK_LVL;
                  bit_cnt_d = 4'd9;
               end else if (scl_fall && bit_cnt_q == 4'd9) begin
                  sda_oe_d  = 1'b0;
                  bit_cnt_d = '0;
                  if (state_q == PTR) begin
                     state_d = WR_DATA;
                  end else if (state_q == ADDR_ACK) begin
                     if (rw_q) begin
                        state_d  = RD_DATA;
                        shreg_d  = rd_byte;
                        sda_oe_d = ~rd_byte[7];
                     end else begin
                        state_d = PTR;
                     end
                  end
               end
            end
            RD_DATA: begin
               if (scl_rise && bit_cnt_q < 4'd8) begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  sda_oe_d  = 1'b0;
                  bit_cnt_d = '0;
                  state_d   = RD_ACK;
               end else if (scl_fall && bit_cnt_q != 4'd0) begin
                  shreg_d  = {shreg_q[6:0], 1'b0};
                  sda_oe_d = ~shreg_q[6];
               end
            end
            RD_ACK: begin
               if (scl_rise && bit_cnt_q == 4'd0) begin
                  if (sda_f == NACK_LVL) begin
                     state_d = IDLE;
                  end else begin
                     ptr_d     = (ptr_q + 8'd1) & PTR_MASK;
                     bit_cnt_d = 4'd1;
                  end
               end else if (scl_fall && bit_cnt_q == 4'd1) begin
                  state_d   = RD_DATA;
                  bit_cnt_d = '0;
                  shreg_d   = rd_byte;
                  sda_oe_d  = ~rd_byte[7];
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk48 or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         ptr_q      <= '0;
         rw_q       <= 1'b0;
         sda_oe_q   <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         ptr_q      <= ptr_d;
         rw_q       <= rw_d;
         sda_oe_q   <= sda_oe_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   always_ff @(posedge clk48 or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wr_valid_d) begin
         regs[wr_addr_d[PW-1:0]] <= wr_data_d;
      end
   end

   assign bus.sda_oe   = sda_oe_q;
   assign bus.wr_valid = wr_valid_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;
   assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_i2c_target_regs.sv
// Bit-banged I2C master driving i2c_target_regs, checked against a
// transaction-level model of the register file and pointer.
module tb_i2c_target_regs;
   localparam int         Q     = 8;
   localparam logic [6:0] TADDR = 7'h50;

   logic clk48   = 1'b0;
   logic reset_n = 1'b0;
   logic sda_m   = 1'b1;
   int   total   = 0;
   int   bad     = 0;

   logic [7:0]  model_regs [16];
   int          model_ptr = 0;
   logic [15:0] exp_q [$];
   logic [15:0] obs_q [$];
   logic [7:0]  wdata [$];
   logic [7:0]  rdata [$];

   i2c_target_regs_if bus();

   i2c_target_regs #(.I2C_ADDR(7'h50), .NUM_REGS(16), .FILTER_LEN(3)) dut (
      .clk48(clk48), .reset_n(reset_n), .bus(bus)
   );

   always #10 clk48 = ~clk48;

   // Wired-AND open-drain bus: either side may pull SDA low.
   assign bus.sda_i = sda_m & ~bus.sda_oe;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Per-cycle compare: every write pulse must match the model's next write,
   // and SDA may only change while SCL is low.
   initial begin
      int scl_run = 0;
      logic prev_oe = 1'b0;
      logic [15:0] e;
      forever begin
         @(negedge clk48);
         scl_run = bus.scl_i ? scl_run + 1 : 0;
         if (reset_n && bus.wr_valid) begin
            obs_q.push_back({bus.wr_addr, bus.wr_data});
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_wr: got 0x%0h expected no write", {bus.wr_addr, bus.wr_data});
            end else begin
               e = exp_q.pop_front();
               check("wr_addr_data", {bus.wr_addr, bus.wr_data}, e);
            end
         end
         if (reset_n && bus.sda_oe !== prev_oe)
            check("oe_change_scl_high", 16'(scl_run >= 8), 16'd0);
         prev_oe = bus.sda_oe;
      end
   end

   task automatic wait_q();
      repeat (Q) @(negedge clk48);
   endtask

   task automatic put_bit(input logic b, input logic glitch);
      sda_m = b;
      wait_q();
      bus.scl_i = 1'b1;
      wait_q();
      if (glitch) begin
         sda_m = ~b;
         @(negedge clk48);
         sda_m = b;
      end
      wait_q();
      bus.scl_i = 1'b0;
      wait_q();
   endtask

   task automatic get_bit(output logic b);
      sda_m = 1'b1;
      wait_q();
      bus.scl_i = 1'b1;
      wait_q();
      b = bus.sda_i;
      wait_q();
      bus.scl_i = 1'b0;
      wait_q();
   endtask

   task automatic i2c_start();
      sda_m = 1'b1;
      wait_q();
      bus.scl_i = 1'b1;
      wait_q();
      sda_m = 1'b0;
      wait_q();
      bus.scl_i = 1'b0;
      wait_q();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0;
      wait_q();
      bus.scl_i = 1'b1;
      wait_q();
      sda_m = 1'b1;
      wait_q();
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack, input int gbit);
      logic nb;
      for (int i = 7; i >= 0; i--) put_bit(d[i], i == gbit);
      get_bit(nb);
      ack = ~nb;
   endtask

   task automatic read_byte(output logic [7:0] d, input logic ack);
      logic b;
      d = '0;
      for (int i = 0; i < 8; i++) begin
         get_bit(b);
         d = {d[6:0], b};
      end
      put_bit(~ack, 1'b0);
   endtask

   task automatic do_write(input logic [7:0] ptr, input int gbit);
      logic ack;
      i2c_start();
      write_byte({TADDR, 1'b0}, ack, -1);
      check("w_addr_ack", 16'(ack), 16'd1);
      check("w_busy", 16'(bus.busy), 16'd1);
      write_byte(ptr, ack, -1);
      check("w_ptr_ack", 16'(ack), 16'd1);
      model_ptr = int'(ptr) % 16;
      foreach (wdata[i]) begin
         exp_q.push_back({8'(model_ptr), wdata[i]});
         model_regs[model_ptr] = wdata[i];
         model_ptr = (model_ptr + 1) % 16;
         write_byte(wdata[i], ack, (i == 0) ? gbit : -1);
         check("w_data_ack", 16'(ack), 16'd1);
      end
      i2c_stop();
      check("w_busy_end", 16'(bus.busy), 16'd0);
      check("w_pending", 16'(exp_q.size()), 16'd0);
   endtask

   task automatic do_read(input logic set_ptr, input logic [7:0] ptr, input int n);
      logic ack;
      logic [7:0] d;
      i2c_start();
      if (set_ptr) begin
         write_byte({TADDR, 1'b0}, ack, -1);
         check("r_waddr_ack", 16'(ack), 16'd1);
         write_byte(ptr, ack, -1);
         check("r_ptr_ack", 16'(ack), 16'd1);
         model_ptr = int'(ptr) % 16;
         i2c_start();
      end
      write_byte({TADDR, 1'b1}, ack, -1);
      check("r_addr_ack", 16'(ack), 16'd1);
      rdata.delete();
      for (int i = 0; i < n; i++) begin
         read_byte(d, i != n - 1);
         check("r_data", 16'(d), 16'(model_regs[model_ptr]));
         rdata.push_back(d);
         if (i != n - 1) model_ptr = (model_ptr + 1) % 16;
      end
      check("r_sda_released", 16'(bus.sda_oe), 16'd0);
      i2c_stop();
      check("r_busy_end", 16'(bus.busy), 16'd0);
   endtask

   task automatic do_bad_addr(input logic [6:0] a, input logic rw);
      logic ack;
      i2c_start();
      write_byte({a, rw}, ack, -1);
      check("bad_addr_nack", 16'(ack), 16'd0);
      wait_q();
      check("bad_addr_busy", 16'(bus.busy), 16'd0);
      i2c_stop();
   endtask

   initial begin
      #(20 * 90000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] a;
      int kind;
      int n;
      bus.scl_i = 1'b1;
      for (int i = 0; i < 16; i++) model_regs[i] = '0;
      repeat (3) @(negedge clk48);
      check("rst_sda_oe", 16'(bus.sda_oe), 16'd0);
      check("rst_wr_valid", 16'(bus.wr_valid), 16'd0);
      check("rst_wr_addr", 16'(bus.wr_addr), 16'd0);
      check("rst_wr_data", 16'(bus.wr_data), 16'd0);
      check("rst_busy", 16'(bus.busy), 16'd0);
      reset_n = 1'b1;
      repeat (20) @(negedge clk48);
      check("idle_busy", 16'(bus.busy), 16'd0);

      // Write A5,5A starting at register 3
      obs_q.delete();
      wdata = '{8'hA5, 8'h5A};
      do_write(8'h03, -1);
      check("t1_wr_count", 16'(obs_q.size()), 16'd2);
      if (obs_q.size() == 2) begin
         check("t1_wr0", obs_q[0], 16'h03A5);
         check("t1_wr1", obs_q[1], 16'h045A);
      end

      // Pointer write, repeated START, read two bytes back
      do_read(1'b1, 8'h03, 2);
      check("t2_rd_count", 16'(rdata.size()), 16'd2);
      if (rdata.size() == 2) begin
         check("t2_rd0", 16'(rdata[0]), 16'h00A5);
         check("t2_rd1", 16'(rdata[1]), 16'h005A);
      end

      // Foreign address
      obs_q.delete();
      do_bad_addr(7'h51, 1'b0);
      check("t3_no_wr", 16'(obs_q.size()), 16'd0);

      // Pointer wrap at the end of the register file
      obs_q.delete();
      wdata = '{8'h11, 8'h22, 8'h33};
      do_write(8'h0F, -1);
      check("t4_wr_count", 16'(obs_q.size()), 16'd3);
      if (obs_q.size() == 3) begin
         check("t4_addr0", 16'(obs_q[0][15:8]), 16'd15);
         check("t4_addr1", 16'(obs_q[1][15:8]), 16'd0);
         check("t4_addr2", 16'(obs_q[2][15:8]), 16'd1);
      end

      // Single-cycle SDA glitches: idle bus, then inside data bits
      @(negedge clk48);
      sda_m = 1'b0;
      @(negedge clk48);
      sda_m = 1'b1;
      repeat (20) @(negedge clk48);
      check("t5_idle_glitch_busy", 16'(bus.busy), 16'd0);
      wdata = '{8'h3C};
      do_write(8'h07, 7);
      wdata = '{8'hC3};
      do_write(8'h08, 7);

      // Randomised transactions
      for (int it = 0; it < 16; it++) begin
         kind = int'($urandom_range(0, 3));
         n = int'($urandom_range(1, 3));
         case (kind)
            0: begin
               wdata.delete();
               for (int i = 0; i < int'($urandom_range(0, 3)); i++) wdata.push_back(8'($urandom));
               do_write(8'($urandom), -1);
            end
            1: do_read(1'b1, 8'($urandom), n);
            2: do_read(1'b0, 8'h00, n);
            default: begin
               a = 7'($urandom);
               if (a == TADDR) a = a ^ 7'h01;
               do_bad_addr(a, 1'($urandom));
            end
         endcase
      end

      // Reset while the target holds its address ACK
      i2c_start();
      for (int i = 7; i >= 0; i--) put_bit(TADDR[6 - (i == 0 ? 0 : 7 - i)] & (i != 0), 1'b0);
      sda_m = 1'b1;
      wait_q();
      bus.scl_i = 1'b1;
      wait_q();
      check("t6_ack_driven", 16'(bus.sda_oe), 16'd1);
      @(posedge clk48);
      #2 reset_n = 1'b0;
      #1 check("t6_rst_release", 16'(bus.sda_oe), 16'd0);
      check("t6_rst_busy", 16'(bus.busy), 16'd0);
      repeat (4) @(negedge clk48);
      reset_n = 1'b1;
      for (int i = 0; i < 16; i++) model_regs[i] = '0;
      model_ptr = 0;
      exp_q.delete();
      wait_q();
      bus.scl_i = 1'b0;
      wait_q();
      i2c_stop();
      do_read(1'b0, 8'h00, 1);
      if (rdata.size() == 1) check("t6_rd_zero", 16'(rdata[0]), 16'h0000);
      check("end_pending", 16'(exp_q.size()), 16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
